// File: rtl/dac_bus_writer.sv
// dac_bus_writer
//   Bus stage between the DAC value source and an 8-bit parallel,
//   dual-channel DAC. It accepts one code per valid/ready handshake and
//   drives the timed csn/wrn/ldacn write-and-load sequence. dac_d keeps the
//   last written code so that display blocks can read it.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   in_valid      source presents a code
//   in_ready      block can accept (high only when idle)
//   in_data       8-bit DAC code
//   in_ch         channel select: 0 = A, 1 = B
//   dac_csn       DAC chip select, active low
//   dac_wrn       DAC write strobe, active low
//   dac_ldacn     DAC load strobe, active low
//   dac_a_b       DAC channel select pin
//   dac_d         DAC data bus / last written code
//   busy          transaction in progress
//   done          one-cycle pulse when a transaction completes
//
// Optional feature (macro DAC_SKIP_DUP_EN)
//   When defined, a code that equals the last completed write on the same
//   channel skips the bus sequence and only produces a done pulse.
module dac_bus_writer #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned WR_CYC    = 4,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned LDAC_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_ch,
    output logic       dac_csn,
    output logic       dac_wrn,
    output logic       dac_ldacn,
    output logic       dac_a_b,
    output logic [7:0] dac_d,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_LATCH,
        ST_SKIP
    } state_t;

    // The counter is loaded with N-1 on state entry, so a phase of N cycles
    // ends on the edge where the counter already reads zero.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] WR_LD    = 8'(WR_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] LDAC_LD  = 8'(LDAC_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
    logic       csn_q, csn_d;
    logic       wrn_q, wrn_d;
    logic       ldacn_q, ldacn_d;
    logic       a_b_q, a_b_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

`ifdef DAC_SKIP_DUP_EN
    logic [1:0] last_vld_q, last_vld_d;
    logic [7:0] last_val_q [2];
    logic [7:0] last_val_d [2];
    logic       dup;

    assign dup = last_vld_q[in_ch] && (last_val_q[in_ch] == in_data);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        csn_d   = csn_q;
        wrn_d   = wrn_q;
        ldacn_d = ldacn_q;
        a_b_d   = a_b_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DAC_SKIP_DUP_EN
        last_vld_d = last_vld_q;
        last_val_d = last_val_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && ready_q) begin
                    data_d  = in_data;
                    a_b_d   = in_ch;
                    ready_d = 1'b0;
`ifdef DAC_SKIP_DUP_EN
                    if (dup) begin
                        state_d = ST_SKIP;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                        csn_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
`else
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_WRITE;
                    cnt_d   = WR_LD;
                    wrn_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    wrn_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_LATCH;
                    cnt_d   = LDAC_LD;
                    csn_d   = 1'b1;
                    ldacn_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ldacn_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
`ifdef DAC_SKIP_DUP_EN
                    last_vld_d[a_b_q] = 1'b1;
                    last_val_d[a_b_q] = data_q;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SKIP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            ldacn_q <= 1'b1;
            a_b_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DAC_SKIP_DUP_EN
            last_vld_q    <= '0;
            last_val_q[0] <= '0;
            last_val_q[1] <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            csn_q   <= csn_d;
            wrn_q   <= wrn_d;
            ldacn_q <= ldacn_d;
            a_b_q   <= a_b_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DAC_SKIP_DUP_EN
            last_vld_q <= last_vld_d;
            last_val_q <= last_val_d;
`endif
        end
    end

    assign in_ready  = ready_q;
    assign dac_csn   = csn_q;
    assign dac_wrn   = wrn_q;
    assign dac_ldacn = ldacn_q;
    assign dac_a_b   = a_b_q;
    assign dac_d     = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dac_bus_writer.sv
// Testbench for dac_bus_writer: one instance with default timing and one
// with all phases set to a single cycle. The expected pin pattern of each
// transaction is derived from its cycle offset after the accepting edge.
module tb_dac_bus_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       c0 = 1'b0, c1 = 1'b0;
    logic       r0, csn0, wrn0, ld0, ab0, busy0, done0;
    logic       r1, csn1, wrn1, ld1, ab1, busy1, done1;
    logic [7:0] q0, q1;

    dac_bus_writer u_dut (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0), .in_ch(c0),
        .dac_csn(csn0), .dac_wrn(wrn0), .dac_ldacn(ld0), .dac_a_b(ab0), .dac_d(q0),
        .busy(busy0), .done(done0)
    );

    dac_bus_writer #(.SETUP_CYC(1), .WR_CYC(1), .HOLD_CYC(1), .LDAC_CYC(1)) u_fast (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_ch(c1),
        .dac_csn(csn1), .dac_wrn(wrn1), .dac_ldacn(ld1), .dac_a_b(ab1), .dac_d(q1),
        .busy(busy1), .done(done1)
    );

    int unsigned ps [2] = '{2, 1};
    int unsigned pw [2] = '{4, 1};
    int unsigned ph [2] = '{2, 1};
    int unsigned pl [2] = '{2, 1};

    // Last completed code per instance and channel (used by the dup-skip model)
    logic       last_ok [2][2];
    logic [7:0] last_v  [2][2];

    int vectors = 0;
    int miscompares = 0;

    // Packed observation: {csn, wrn, ldacn, done, busy, in_ready, a_b, d[7:0]}
    function automatic logic [14:0] obs(int sel);
        if (sel == 0) return {csn0, wrn0, ld0, done0, busy0, r0, ab0, q0};
        return {csn1, wrn1, ld1, done1, busy1, r1, ab1, q1};
    endfunction

    function automatic logic [14:0] idle_vec(logic [7:0] data, logic ch);
        return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ch, data};
    endfunction

    // Expected pins k cycles after the accepting edge
    function automatic logic [14:0] model(int sel, int unsigned k, logic [7:0] data,
                                          logic ch, bit skip);
        int unsigned s, w, h, t;
        s = ps[sel];
        w = pw[sel];
        h = ph[sel];
        t = s + w + h + pl[sel];
        if (skip)
            return {1'b1, 1'b1, 1'b1, (k == 1), 1'b0, (k >= 1), ch, data};
        return {!(k < s + w + h), !(k >= s && k < s + w), !(k >= s + w + h && k < t),
                (k == t), (k < t), (k >= t), ch, data};
    endfunction

    function automatic bit is_dup(int sel, logic [7:0] data, logic ch);
`ifdef DAC_SKIP_DUP_EN
        return last_ok[sel][ch] && (last_v[sel][ch] == data);
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_in(int sel, logic v, logic [7:0] d, logic c);
        if (sel == 0) begin
            v0 = v; d0 = d; c0 = c;
        end else begin
            v1 = v; d1 = d; c1 = c;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                last_ok[i][j] = 1'b0;
                last_v[i][j]  = '0;
            end
    endtask

    // Called with in_valid already raised before the accepting edge.
    task automatic expect_txn(int sel, logic [7:0] data, logic ch, logic nv,
                              logic [7:0] nd, logic nc, string name);
        bit skip;
        int unsigned t;
        logic [14:0] exp_v, got;
        skip = is_dup(sel, data, ch);
        t = skip ? 1 : ps[sel] + pw[sel] + ph[sel] + pl[sel];
        for (int unsigned k = 0; k <= t; k++) begin
            @(negedge clk);
            exp_v = model(sel, k, data, ch, skip);
            got = obs(sel);
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL %s k=%0d got=%h want=%h", name, k, got, exp_v);
            end
            if (k == 0) set_in(sel, nv, nd, nc);
        end
        last_ok[sel][ch] = 1'b1;
        last_v[sel][ch]  = data;
        if (!nv) begin
            @(negedge clk);
            exp_v = idle_vec(data, ch);
            got = obs(sel);
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL %s_after got=%h want=%h", name, got, exp_v);
            end
        end
    endtask

    task automatic write(int sel, logic [7:0] data, logic ch, string name);
        set_in(sel, 1'b1, data, ch);
        expect_txn(sel, data, ch, 1'b0, 8'h00, 1'b0, name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                vectors++;
                if (obs(s) !== idle_vec(8'h00, 1'b0)) begin
                    miscompares++;
                    $display("FAIL reset_idle inst=%0d got=%h want=%h", s, obs(s),
                             idle_vec(8'h00, 1'b0));
                end
            end
        end
    endtask

    task automatic test_single();
        write(0, 8'hA5, 1'b1, "single_a5");
    endtask

    task automatic test_back_to_back();
        set_in(0, 1'b1, 8'h10, 1'b0);
        expect_txn(0, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, "b2b_first");
        expect_txn(0, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        logic [14:0] got;
        set_in(0, 1'b1, 8'h44, 1'b0);
        for (int unsigned k = 0; k <= 5; k++) begin
            @(negedge clk);
            got = obs(0);
            vectors++;
            if (got !== model(0, k, 8'h44, 1'b0, 1'b0)) begin
                miscompares++;
                $display("FAIL rstmid_pre k=%0d got=%h want=%h", k, got,
                         model(0, k, 8'h44, 1'b0, 1'b0));
            end
            if (k == 0) set_in(0, 1'b0, 8'h00, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            got = obs(0);
            vectors++;
            if (got !== idle_vec(8'h00, 1'b0)) begin
                miscompares++;
                $display("FAIL rstmid_idle i=%0d got=%h want=%h", i, got,
                         idle_vec(8'h00, 1'b0));
            end
            @(negedge clk);
        end
        write(0, 8'h33, 1'b0, "rstmid_after_33");
    endtask

    task automatic test_fast();
        write(1, 8'hFF, 1'b0, "fast_ff");
    endtask

    task automatic test_dup_codes();
        write(0, 8'h40, 1'b0, "dup_first");
        write(0, 8'h40, 1'b0, "dup_repeat");
        write(0, 8'h40, 1'b1, "dup_other_ch");
    endtask

    task automatic test_random();
        int sel;
        logic [7:0] data;
        logic ch;
        for (int i = 0; i < 40; i++) begin
            sel  = int'($urandom_range(0, 1));
            data = ($urandom_range(0, 2) == 0) ? 8'h40 : 8'($urandom);
            ch   = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            write(sel, data, ch, "random");
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_fast();
        test_dup_codes();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
